// File: rtl/axi_rd_master.sv
// rtl/axi_rd_master.sv - single-burst AXI read master: one AR, collects R beats, flags faulty bursts.
module axi_rd_master #(
   parameter int         AXI_WIDTH = 64,
   parameter logic [3:0] AXI_ID    = 4'b0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rd_start,
   input  logic [29:0]          rd_addr,
   input  logic [7:0]           rd_len,
   output logic                 rd_done,
   output logic                 rd_err,
   output logic                 rd_busy,
   output logic [AXI_WIDTH-1:0] rd_data,
   output logic                 rd_data_valid,
   output logic [3:0]           m_axi_arid,
   output logic [29:0]          m_axi_araddr,
   output logic [7:0]           m_axi_arlen,
   output logic [2:0]           m_axi_arsize,
   output logic [1:0]           m_axi_arburst,
   output logic                 m_axi_arvalid,
   input  logic                 m_axi_arready,
   input  logic [3:0]           m_axi_rid,
   input  logic [AXI_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]           m_axi_rresp,
   input  logic                 m_axi_rlast,
   input  logic                 m_axi_rvalid,
   output logic                 m_axi_rready
);

   typedef enum logic [1:0] {IDLE, RA, RD, DONE} state_t;

   localparam logic [2:0] ARSIZE = 3'($clog2(AXI_WIDTH / 8));

   state_t                state_q, state_d;
   logic [29:0]           araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [8:0]            cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [AXI_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                  rd_data_valid_q, rd_data_valid_d;

   logic beat;
   logic cnt_at_len;
   logic last_beat;
   logic beat_err;

   assign beat       = m_axi_rvalid && (state_q == RD);
   assign cnt_at_len = (cnt_q == {1'b0, arlen_q});
   // The burst ends on rlast or on the beat that completes arlen+1, whichever comes first.
   assign last_beat  = beat && (m_axi_rlast || cnt_at_len);
   assign beat_err   = (m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID) ||
                       (m_axi_rlast != cnt_at_len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         araddr_q        <= '0;
         arlen_q         <= '0;
         cnt_q           <= '0;
         err_q           <= 1'b0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         araddr_q        <= araddr_d;
         arlen_q         <= arlen_d;
         cnt_q           <= cnt_d;
         err_q           <= err_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rd_start) state_d = RA;
         RA:      if (m_axi_arready) state_d = RD;
         RD:      if (last_beat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      araddr_d        = araddr_q;
      arlen_d         = arlen_q;
      cnt_d           = cnt_q;
      err_d           = err_q;
      rd_data_d       = rd_data_q;
      rd_data_valid_d = beat;
      if (state_q == IDLE) begin
         err_d = 1'b0;
         if (rd_start) begin
            araddr_d = rd_addr;
            arlen_d  = rd_len;
         end
      end
      if ((state_q == RA) && m_axi_arready) cnt_d = '0;
      if (beat) begin
         cnt_d     = cnt_q + 9'd1;
         rd_data_d = m_axi_rdata;
         if (beat_err) err_d = 1'b1;
      end
   end

   always_comb begin
      m_axi_arid    = AXI_ID;
      m_axi_araddr  = araddr_q;
      m_axi_arlen   = arlen_q;
      m_axi_arsize  = ARSIZE;
      m_axi_arburst = 2'b01;
      m_axi_arvalid = (state_q == RA);
      m_axi_rready  = (state_q == RD);
      rd_busy       = (state_q != IDLE);
      rd_done       = (state_q == DONE);
      rd_err        = (state_q == DONE) && err_q;
      rd_data       = rd_data_q;
      rd_data_valid = rd_data_valid_q;
   end

endmodule

// File: tb/tb_axi_rd_master.sv
// tb/tb_axi_rd_master.sv - directed-vector bench for axi_rd_master.
module tb_axi_rd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_start;
   logic [29:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_done, rd_err, rd_busy, rd_data_valid;
   logic [63:0] rd_data;
   logic [3:0]  m_axi_arid;
   logic [29:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid, m_axi_arready;
   logic [3:0]  m_axi_rid;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   axi_rd_master #(.AXI_WIDTH(64), .AXI_ID(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_done(rd_done), .rd_err(rd_err), .rd_busy(rd_busy),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] bdata(input logic [29:0] addr, input int i);
      return {32'hC0DE_0000 + 32'(i), 2'b00, addr};
   endfunction

   // Issues one burst with arready high; beat last_idx carries rlast (-1: never).
   task automatic burst(input logic [29:0] addr, input logic [7:0] len, input int nbeats,
                        input int last_idx, input logic [1:0] resp, input logic [3:0] rid,
                        input logic exp_err);
      m_axi_arready = 1'b1;
      rd_start = 1'b1; rd_addr = addr; rd_len = len;
      step();
      chk("ra_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("ra_araddr", 64'(m_axi_araddr), 64'(addr));
      chk("ra_arlen", 64'(m_axi_arlen), 64'(len));
      rd_start = 1'b0;
      step();
      chk("rd_rready", 64'(m_axi_rready), 64'd1);
      chk("rd_arvalid", 64'(m_axi_arvalid), 64'd0);
      for (int i = 0; i < nbeats; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rdata = bdata(addr, i);
         m_axi_rlast = (i == last_idx); m_axi_rresp = resp; m_axi_rid = rid;
         step();
         chk("beat_valid", 64'(rd_data_valid), 64'd1);
         chk("beat_data", rd_data, bdata(addr, i));
         chk("beat_done", 64'(rd_done), (i == nbeats - 1) ? 64'd1 : 64'd0);
      end
      chk("done_err", 64'(rd_err), 64'(exp_err));
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rid = 4'h0;
      step();
      chk("idle_done", 64'(rd_done), 64'd0);
      chk("idle_busy", 64'(rd_busy), 64'd0);
      chk("idle_dv", 64'(rd_data_valid), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; rd_start = 1'b0; rd_addr = '0; rd_len = '0;
      m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
      step(); step();
      chk("rst_busy", 64'(rd_busy), 64'd0);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_rready", 64'(m_axi_rready), 64'd0);
      chk("rst_done", 64'(rd_done), 64'd0);
      chk("rst_data", rd_data, 64'd0);
      chk("arsize", 64'(m_axi_arsize), 64'd3);
      chk("arburst", 64'(m_axi_arburst), 64'd1);
      chk("arid", 64'(m_axi_arid), 64'd0);
      rst_n = 1'b1;
      step();

      // 8-beat clean burst
      burst(30'h100, 8'd7, 8, 7, 2'b00, 4'h0, 1'b0);

      // AR stalled 5 cycles; rd_addr changes during RA are ignored
      m_axi_arready = 1'b0;
      rd_start = 1'b1; rd_addr = 30'h200; rd_len = 8'd1;
      step();
      rd_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_addr = 30'h3FF_0000 + 30'(i);
         step();
         chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
         chk("stall_araddr", 64'(m_axi_araddr), 64'h200);
         chk("stall_arlen", 64'(m_axi_arlen), 64'd1);
      end
      m_axi_arready = 1'b1;
      step();
      chk("stall_rready", 64'(m_axi_rready), 64'd1);
      for (int i = 0; i < 2; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rdata = bdata(30'h200, i); m_axi_rlast = (i == 1);
         step();
         chk("stall_data", rd_data, bdata(30'h200, i));
      end
      chk("stall_done", 64'(rd_done), 64'd1);
      chk("stall_err", 64'(rd_err), 64'd0);
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      step();

      // error cases, then a clean burst clears the flag
      burst(30'h040, 8'd0, 1, 0, 2'b10, 4'h0, 1'b1);
      burst(30'h080, 8'd0, 1, 0, 2'b00, 4'h0, 1'b0);
      burst(30'h010, 8'd3, 2, 1, 2'b00, 4'h0, 1'b1);
      burst(30'h020, 8'd3, 4, -1, 2'b00, 4'h0, 1'b1);
      burst(30'h030, 8'd1, 2, 1, 2'b00, 4'h5, 1'b1);

      // rd_start held across two bursts; rvalid in the gap is ignored
      rd_start = 1'b1; rd_addr = 30'h500; rd_len = 8'd0;
      step();
      step();
      m_axi_rvalid = 1'b1; m_axi_rdata = bdata(30'h500, 0); m_axi_rlast = 1'b1;
      step();
      chk("b2b_done", 64'(rd_done), 64'd1);
      rd_addr = 30'h600; m_axi_rdata = 64'hBAD;
      step();
      chk("b2b_gap_busy", 64'(rd_busy), 64'd0);
      chk("b2b_gap_rready", 64'(m_axi_rready), 64'd0);
      chk("b2b_gap_dv", 64'(rd_data_valid), 64'd0);
      step();
      chk("b2b_araddr", 64'(m_axi_araddr), 64'h600);
      chk("b2b_ra_dv", 64'(rd_data_valid), 64'd0);
      chk("b2b_hold_data", rd_data, bdata(30'h500, 0));
      rd_start = 1'b0; m_axi_rvalid = 1'b0;
      step();
      m_axi_rvalid = 1'b1; m_axi_rdata = bdata(30'h600, 0);
      step();
      chk("b2b_done2", 64'(rd_done), 64'd1);
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      step();

      // reset asserted at the 3rd beat of a 16-beat burst
      rd_start = 1'b1; rd_addr = 30'h700; rd_len = 8'd15;
      step();
      rd_start = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         m_axi_rvalid = 1'b1; m_axi_rdata = bdata(30'h700, i);
         step();
      end
      m_axi_rdata = bdata(30'h700, 2);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(rd_busy), 64'd0);
      chk("mrst_rready", 64'(m_axi_rready), 64'd0);
      chk("mrst_dv", 64'(rd_data_valid), 64'd0);
      chk("mrst_data", rd_data, 64'd0);
      chk("mrst_araddr", 64'(m_axi_araddr), 64'd0);
      chk("mrst_arlen", 64'(m_axi_arlen), 64'd0);
      step();
      rst_n = 1'b1;
      rd_start = 1'b1; rd_addr = 30'h7F0; rd_len = 8'd0;
      step();
      chk("post_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("post_araddr", 64'(m_axi_araddr), 64'h7F0);
      chk("post_dv", 64'(rd_data_valid), 64'd0);
      rd_start = 1'b0; m_axi_rvalid = 1'b0;
      step();
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = bdata(30'h7F0, 0);
      step();
      chk("post_done", 64'(rd_done), 64'd1);
      chk("post_err", 64'(rd_err), 64'd0);
      chk("post_data", rd_data, bdata(30'h7F0, 0));
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
